// File: rtl/fetch_decode_queue_pkg.sv
// Shared constants for the fetch/decode front end: instruction/PC widths and
// the canonical NOP (addi x0,x0,0) that decode sees when nothing is queued.
package fetch_decode_queue_pkg;

   localparam int INSTR_SIZE = 32;
   localparam int PC_SIZE    = 32;

   localparam logic [INSTR_SIZE-1:0] nop_inst = 32'h00000013;

endpackage

// File: rtl/fetch_decode_queue.sv
// Instruction queue between fetch and decode: buffers {instr, pc+4} pairs,
// presents the head entry (or a NOP when empty), and drops everything on redirect.
module fetch_decode_queue
   import fetch_decode_queue_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int INSTR_W = INSTR_SIZE,
   parameter int PC_W    = PC_SIZE,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = $clog2(DEPTH+1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_push_valid,
   input  logic [INSTR_W-1:0] i_push_instr,
   input  logic [PC_W-1:0]    i_push_pc,
   output logic               o_full,
   input  logic               i_flush,
   input  logic               i_pop_ready,
   output logic               o_out_valid,
   output logic [INSTR_W-1:0] o_out_instr,
   output logic [PC_W-1:0]    o_out_pc,
   output logic [CW-1:0]      o_count,
   output logic               o_ovf_err
);

   localparam int EW = INSTR_W + PC_W;

   logic [EW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_ovf_err;

   logic          w_full, w_valid, w_pop_ok, w_push_ok, w_ovf;
   logic [EW-1:0] w_head;

   assign w_full    = (r_count == CW'(DEPTH));
   assign w_valid   = (r_count != '0);
   assign w_pop_ok  = i_pop_ready & w_valid & ~i_flush;
   assign w_push_ok = i_push_valid & (~w_full | w_pop_ok) & ~i_flush;
   assign w_ovf     = i_push_valid & w_full & ~w_pop_ok & ~i_flush;
   assign w_head    = r_mem[r_rd_ptr];

   // Outputs depend only on registered state; fetch never sees a comb path from decode.
   assign o_full      = w_full;
   assign o_out_valid = w_valid;
   assign o_out_instr = w_valid ? w_head[EW-1:PC_W] : INSTR_W'(nop_inst);
   assign o_out_pc    = w_valid ? w_head[PC_W-1:0] : '0;
   assign o_count     = r_count;
   assign o_ovf_err   = r_ovf_err;

   // Storage carries no reset; occupancy alone decides what is valid.
   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= {i_push_instr, i_push_pc};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_ovf_err <= 1'b0;
      end else begin
         if (w_ovf) r_ovf_err <= 1'b1;
         if (i_flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
         end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push_ok && !w_pop_ok)      r_count <= r_count + CW'(1);
            else if (w_pop_ok && !w_push_ok) r_count <= r_count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Scoreboard bench for fetch_decode_queue: accepted pushes are queued with
// their expected contents and compared against the head as decode pops them.
module tb_fetch_decode_queue;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst;
   logic        push_valid, flush, pop_ready;
   logic [31:0] push_instr, push_pc;
   logic        full, out_valid, ovf_err;
   logic [31:0] out_instr, out_pc;
   logic [2:0]  count;

   int checks = 0;
   int errors = 0;
   logic [63:0] sb[$];
   bit exp_ovf = 0;

   always #5 clk = ~clk;

   fetch_decode_queue #(.DEPTH(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_push_valid(push_valid), .i_push_instr(push_instr), .i_push_pc(push_pc),
      .o_full(full), .i_flush(flush), .i_pop_ready(pop_ready),
      .o_out_valid(out_valid), .o_out_instr(out_instr), .o_out_pc(out_pc),
      .o_count(count), .o_ovf_err(ovf_err)
   );

   function automatic logic [63:0] ent(input int i);
      logic [31:0] ins, pc;
      ins = 32'hA000_0000 + 32'(i);
      pc  = 32'(4 * (i + 1));
      return {ins, pc};
   endfunction

   // Drive one cycle of stimulus and advance the scoreboard with the same rules
   // the queue is meant to follow; outputs are sampled 1ns after the edge.
   task automatic step(input bit pv, input logic [63:0] e, input bit pop, input bit fl);
      bit pop_ok, push_ok;
      push_valid = pv; push_instr = e[63:32]; push_pc = e[31:0];
      pop_ready = pop; flush = fl;
      pop_ok  = pop && sb.size() != 0 && !fl;
      push_ok = pv && (sb.size() < DEPTH || pop_ok) && !fl;
      if (pv && sb.size() == DEPTH && !pop_ok && !fl) exp_ovf = 1;
      @(posedge clk); #1;
      if (fl) sb.delete();
      else begin
         if (pop_ok) void'(sb.pop_front());
         if (push_ok) sb.push_back(e);
      end
      push_valid = 0; pop_ready = 0; flush = 0;
   endtask

   task automatic test_reset;
      rst = 1; push_valid = 0; push_instr = 0; push_pc = 0; flush = 0; pop_ready = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      sb.delete(); exp_ovf = 0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'h0) begin
         errors++;
         $display("FAIL reset_head valid=%b instr=%h pc=%h want 0/%h/0", out_valid, out_instr, out_pc, NOP);
      end
      checks++;
      if (count !== 3'd0 || full !== 1'b0 || ovf_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state count=%0d full=%b ovf=%b want 0/0/0", count, full, ovf_err);
      end
   endtask

   task automatic test_fill_drain;
      for (int i = 0; i < 4; i++) step(1, ent(i), 0, 0);
      checks++;
      if (count !== 3'd4 || full !== 1'b1) begin
         errors++;
         $display("FAIL fill_count count=%0d full=%b want 4/1", count, full);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({out_instr, out_pc} !== sb[0] || {out_instr, out_pc} !== ent(i) || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL drain_head%0d got %h_%h want %h", i, out_instr, out_pc, ent(i));
         end
         step(0, 64'h0, 1, 0);
      end
      checks++;
      if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'h0 || count !== 3'd0) begin
         errors++;
         $display("FAIL drain_empty valid=%b instr=%h pc=%h count=%0d want 0/%h/0/0", out_valid, out_instr, out_pc, count, NOP);
      end
      // Pop request on an empty queue must be ignored.
      step(0, 64'h0, 1, 0);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL pop_empty count=%0d valid=%b want 0/0", count, out_valid);
      end
   endtask

   task automatic test_full_push_pop;
      for (int i = 0; i < 4; i++) step(1, ent(i), 0, 0);
      step(1, ent(4), 1, 0);
      checks++;
      if (count !== 3'd4 || {out_instr, out_pc} !== ent(1) || ovf_err !== 1'b0) begin
         errors++;
         $display("FAIL full_push_pop count=%0d head=%h_%h ovf=%b want 4/%h/0", count, out_instr, out_pc, ovf_err, ent(1));
      end
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if ({out_instr, out_pc} !== sb[0] || {out_instr, out_pc} !== ent(i)) begin
            errors++;
            $display("FAIL fpp_order%0d got %h_%h want %h", i, out_instr, out_pc, ent(i));
         end
         step(0, 64'h0, 1, 0);
      end
   endtask

   task automatic test_overflow;
      for (int i = 0; i < 4; i++) step(1, ent(i), 0, 0);
      step(1, ent(5), 0, 0);
      checks++;
      if (count !== 3'd4 || ovf_err !== 1'b1 || exp_ovf !== 1'b1 || {out_instr, out_pc} !== ent(0)) begin
         errors++;
         $display("FAIL overflow count=%0d ovf=%b head=%h_%h want 4/1/%h", count, ovf_err, out_instr, out_pc, ent(0));
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if ({out_instr, out_pc} !== sb[0]) begin
            errors++;
            $display("FAIL ovf_order%0d got %h_%h want %h", i, out_instr, out_pc, sb[0]);
         end
         step(0, 64'h0, 1, 0);
      end
      checks++;
      if (out_valid !== 1'b0 || ovf_err !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky valid=%b ovf=%b want 0/1", out_valid, ovf_err);
      end
   endtask

   task automatic test_flush;
      step(1, ent(6), 0, 0);
      step(1, ent(7), 0, 0);
      checks++;
      if (count !== 3'd2) begin
         errors++;
         $display("FAIL flush_pre count=%0d want 2", count);
      end
      step(1, ent(8), 1, 1);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'h0) begin
         errors++;
         $display("FAIL flush count=%0d valid=%b instr=%h pc=%h want 0/0/%h/0", count, out_valid, out_instr, out_pc, NOP);
      end
      step(0, 64'h0, 0, 0);
      checks++;
      if (count !== 3'd0 || out_valid !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL flush_absent count=%0d valid=%b want 0/0", count, out_valid);
      end
      // Queue must be usable right after the flush.
      step(1, ent(9), 0, 0);
      checks++;
      if ({out_instr, out_pc} !== ent(9) || count !== 3'd1) begin
         errors++;
         $display("FAIL post_flush head=%h_%h count=%0d want %h/1", out_instr, out_pc, count, ent(9));
      end
      step(0, 64'h0, 1, 0);
   endtask

   task automatic test_wrap_reset;
      step(1, ent(10), 0, 0);
      for (int i = 11; i < 21; i++) begin
         checks++;
         if ({out_instr, out_pc} !== sb[0] || {out_instr, out_pc} !== ent(i - 1) || count !== 3'd1) begin
            errors++;
            $display("FAIL wrap%0d got %h_%h count=%0d want %h/1", i, out_instr, out_pc, count, ent(i - 1));
         end
         step(1, ent(i), 1, 0);
      end
      step(1, ent(21), 0, 0);
      checks++;
      if (count !== 3'd2 || out_valid !== 1'b1 || ovf_err !== 1'b1) begin
         errors++;
         $display("FAIL wrap_pre_rst count=%0d valid=%b ovf=%b want 2/1/1", count, out_valid, ovf_err);
      end
      #3 rst = 1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_instr !== NOP || out_pc !== 32'h0 || count !== 3'd0 ||
          full !== 1'b0 || ovf_err !== 1'b0) begin
         errors++;
         $display("FAIL async_rst valid=%b instr=%h pc=%h count=%0d full=%b ovf=%b want 0/%h/0/0/0/0",
                  out_valid, out_instr, out_pc, count, full, ovf_err, NOP);
      end
      @(posedge clk); #1 rst = 0;
      sb.delete(); exp_ovf = 0;
      step(1, ent(22), 0, 0);
      checks++;
      if ({out_instr, out_pc} !== ent(22) || count !== 3'd1) begin
         errors++;
         $display("FAIL post_rst head=%h_%h count=%0d want %h/1", out_instr, out_pc, count, ent(22));
      end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_full_push_pop();
      test_overflow();
      test_flush();
      test_wrap_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
